// File: rtl/led_chaser_pkg.sv
// Shared encodings and default parameters for the LED chaser.
package led_chaser_pkg;

  localparam logic [1:0] ST_STOP   = 2'd0;
  localparam logic [1:0] ST_LEFT   = 2'd1;
  localparam logic [1:0] ST_RIGHT  = 2'd2;
  localparam logic [1:0] ST_BOUNCE = 2'd3;

  localparam logic PAT_ONEHOT  = 1'b0;
  localparam logic PAT_JOHNSON = 1'b1;

  localparam int DEF_N_LED       = 4;
  localparam int DEF_TICK_CYCLES = 50_000_000;
  localparam int DEF_DEB_CYCLES  = 1_000_000;

endpackage

// File: rtl/led_key_debounce.sv
// Active-low pushbutton: 2-flop synchroniser, symmetric debounce, one-cycle press pulse.
module led_key_debounce
  import led_chaser_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          held;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      held  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      // key is active-low, so sync2 == held means the pin disagrees with the debounced state
      if (sync2 == held) begin
        if (cnt == LAST) begin
          cnt   <= '0;
          held  <= ~held;
          press <= ~held;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_chaser.sv
// LED chaser: key-driven run-state FSM, speed-scaled tick counter and one-hot/Johnson shifter.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_LED       = DEF_N_LED,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_stop,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic [1:0]       run_state,
  output logic             pattern
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic p_stop, p_left, p_right, p_mode;

  led_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop  (.clk(clk), .rst(rst), .key(key_stop),  .press(p_stop));
  led_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk(clk), .rst(rst), .key(key_left),  .press(p_left));
  led_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk(clk), .rst(rst), .key(key_right), .press(p_right));
  led_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode  (.clk(clk), .rst(rst), .key(key_mode),  .press(p_mode));

  logic [31:0]      period;
  logic [TW-1:0]    tick_last;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [1:0]       state_n;
  logic             toggle;
  logic             changed;
  logic             dir;
  logic [N_LED-1:0] shl;
  logic [N_LED-1:0] shr;
  logic             at_top;
  logic             at_bottom;

  // Terminal count is compared with >= so lowering the period mid-count still wraps
  assign period    = 32'(TICK_CYCLES) >> speed;
  assign tick_last = (period > 32'd1) ? TW'(period - 32'd1) : '0;
  assign tick      = (tick_cnt >= tick_last);

  always_comb begin
    state_n = run_state;
    toggle  = 1'b0;
    if (p_stop) begin
      state_n = ST_STOP;
    end else if (p_left) begin
      state_n = ST_LEFT;
    end else if (p_right) begin
      state_n = ST_RIGHT;
    end else begin
      case (run_state)
        ST_STOP:                     if (p_mode) state_n = ST_BOUNCE;
        ST_LEFT, ST_RIGHT, ST_BOUNCE: toggle = p_mode;
        default:                     state_n = ST_STOP;
      endcase
    end
  end

  assign changed = (state_n != run_state);

  assign shl = {led[N_LED-2:0], (pattern == PAT_JOHNSON) ? ~led[N_LED-1] : led[N_LED-1]};
  assign shr = {(pattern == PAT_JOHNSON) ? ~led[0] : led[0], led[N_LED-1:1]};

  // Bounce turns around on the step that lands on the end of the pattern
  assign at_top    = (pattern == PAT_JOHNSON) ? (&shl)  : shl[N_LED-1];
  assign at_bottom = (pattern == PAT_JOHNSON) ? ~(|shr) : shr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_state <= ST_STOP;
      pattern   <= PAT_ONEHOT;
      led       <= {{(N_LED-1){1'b0}}, 1'b1};
      dir       <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      run_state <= state_n;

      if (changed || toggle || tick) tick_cnt <= '0;
      else                           tick_cnt <= tick_cnt + 1'b1;

      if (toggle) begin
        pattern <= ~pattern;
        led     <= (pattern == PAT_JOHNSON) ? {{(N_LED-1){1'b0}}, 1'b1} : '0;
        dir     <= 1'b0;
      end else if (changed) begin
        if (state_n == ST_BOUNCE) dir <= 1'b0;
      end else if (tick) begin
        case (run_state)
          ST_LEFT:  led <= shl;
          ST_RIGHT: led <= shr;
          ST_BOUNCE: begin
            if (dir) begin
              led <= shr;
              if (at_bottom) dir <= 1'b0;
            end else begin
              led <= shl;
              if (at_top) dir <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Randomised bench for led_chaser against a position-index model of the chase patterns.
module tb_led_chaser;

  localparam int N    = 4;
  localparam int TICK = 8;
  localparam int DEB  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_stop = 1'b1;
  logic         key_left = 1'b1;
  logic         key_right = 1'b1;
  logic         key_mode = 1'b1;
  logic [1:0]   speed = 2'd0;
  logic [N-1:0] led;
  logic [1:0]   run_state;
  logic         pattern;

  always #5 clk = ~clk;

  led_chaser #(.N_LED(N), .TICK_CYCLES(TICK), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst),
    .key_stop(key_stop), .key_left(key_left), .key_right(key_right), .key_mode(key_mode),
    .speed(speed), .led(led), .run_state(run_state), .pattern(pattern)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: state 0..3, pattern, position index within the pattern cycle, bounce direction, tick age
  int ms, mpat, midx, mdir, mage;
  int rel_at[4];
  int ev_cyc[$];
  int ev_key[$];

  function automatic logic [N-1:0] exp_led();
    int full;
    full = (1 << N) - 1;
    if (mpat == 0) return N'(1 << midx);
    if (midx <= N) return N'((1 << midx) - 1);
    return N'((full << (midx - N)) & full);
  endfunction

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_stop  = v;
      1: key_left  = v;
      2: key_right = v;
      default: key_mode = v;
    endcase
  endtask

  task automatic model_reset();
    ms = 0; mpat = 0; midx = 0; mdir = 0; mage = 0;
    ev_cyc.delete();
    ev_key.delete();
    for (int k = 0; k < 4; k++) begin
      rel_at[k] = -1;
      set_key(k, 1'b1);
    end
  endtask

  task automatic model_move();
    int len, top;
    len = (mpat != 0) ? 2 * N : N;
    top = (mpat != 0) ? N : N - 1;
    case (ms)
      1: midx = (midx + 1) % len;
      2: midx = (midx + len - 1) % len;
      3: begin
        if (mdir == 0) begin
          midx = (midx + 1) % len;
          if (midx == top) mdir = 1;
        end else begin
          midx = (midx + len - 1) % len;
          if (midx == 0) mdir = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    bit hit[4];
    int nst, per;
    bit chg;
    hit = '{default: 1'b0};
    for (int i = ev_cyc.size() - 1; i >= 0; i--) begin
      if (ev_cyc[i] == cyc) begin
        hit[ev_key[i]] = 1'b1;
        ev_cyc.delete(i);
        ev_key.delete(i);
      end
    end
    nst = ms;
    chg = 1'b0;
    if (hit[0]) nst = 0;
    else if (hit[1]) nst = 1;
    else if (hit[2]) nst = 2;
    else if (hit[3]) begin
      if (ms == 0) nst = 3;
      else begin
        mpat = 1 - mpat; midx = 0; mdir = 0; chg = 1'b1;
      end
    end
    if (nst != ms) begin
      ms = nst;
      if (ms == 3) mdir = 0;
      chg = 1'b1;
    end
    if (chg) mage = 0;
    else begin
      per = TICK >> speed;
      if (per < 1) per = 1;
      if (mage >= per - 1) begin
        mage = 0;
        if (ms != 0) model_move();
      end else begin
        mage++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (rel_at[k] == cyc) begin
        set_key(k, 1'b1);
        rel_at[k] = -1;
      end
    end
  endtask

  // Key k low for hold sampled cycles; a hold of at least DEB yields one press effect
  task automatic press(input int k, input int hold);
    set_key(k, 1'b0);
    rel_at[k] = cyc + hold;
    if (hold >= DEB) begin
      ev_cyc.push_back(cyc + DEB + 3);
      ev_key.push_back(k);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0001 || run_state !== 2'd0 || pattern !== 1'b0) begin
      failures++;
      $display("FAIL reset_async led=%b state=%0d pattern=%0d expected 0001/0/0", led, run_state, pattern);
    end
    model_reset();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (led !== 4'b0001 || run_state !== 2'd0 || pattern !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d led=%b state=%0d pattern=%0d expected 0001/0/0", cyc, led, run_state, pattern);
      end
    end
  endtask

  task automatic test_left_glitch();
    press(1, 10);
    for (int i = 0; i < 70; i++) begin
      if (i == 35) press(2, 2);
      step();
      checks++;
      if (led !== exp_led() || run_state !== 2'(ms) || pattern !== 1'(mpat)) begin
        failures++;
        $display("FAIL left_glitch cyc=%0d led=%b/%b state=%0d/%0d pattern=%0d/%0d",
                 cyc, led, exp_led(), run_state, ms, pattern, mpat);
      end
    end
    checks++;
    if (run_state !== 2'd1) begin
      failures++;
      $display("FAIL left_after_glitch state=%0d expected 1", run_state);
    end
  endtask

  task automatic test_johnson_left();
    press(3, 10);
    for (int i = 0; i < 90; i++) begin
      step();
      checks++;
      if (led !== exp_led() || run_state !== 2'(ms) || pattern !== 1'(mpat)) begin
        failures++;
        $display("FAIL johnson_left cyc=%0d led=%b/%b state=%0d/%0d pattern=%0d/%0d",
                 cyc, led, exp_led(), run_state, ms, pattern, mpat);
      end
    end
  endtask

  task automatic test_bounce();
    pulse_reset();
    press(3, 10);
    for (int i = 0; i < 190; i++) begin
      if (i == 80) press(3, 10);
      step();
      checks++;
      if (led !== exp_led() || run_state !== 2'(ms) || pattern !== 1'(mpat)) begin
        failures++;
        $display("FAIL bounce cyc=%0d led=%b/%b state=%0d/%0d pattern=%0d/%0d",
                 cyc, led, exp_led(), run_state, ms, pattern, mpat);
      end
    end
  endtask

  task automatic test_priority_speed();
    logic [N-1:0] frozen;
    pulse_reset();
    press(1, 10);
    for (int i = 0; i < 95; i++) begin
      if (i == 30) begin
        press(0, 10);
        press(2, 10);
      end
      if (i == 60) begin
        frozen = led;
        speed = 2'd3;
        press(2, 10);
      end
      step();
      checks++;
      if (led !== exp_led() || run_state !== 2'(ms) || pattern !== 1'(mpat)) begin
        failures++;
        $display("FAIL priority_speed cyc=%0d led=%b/%b state=%0d/%0d pattern=%0d/%0d",
                 cyc, led, exp_led(), run_state, ms, pattern, mpat);
      end
      if (i == 59) begin
        checks++;
        if (run_state !== 2'd0) begin
          failures++;
          $display("FAIL stop_wins state=%0d expected 0", run_state);
        end
      end
      if (i == 66) begin
        checks++;
        if (led !== frozen) begin
          failures++;
          $display("FAIL stop_frozen led=%b expected %b", led, frozen);
        end
      end
    end
    speed = 2'd0;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    press(3, 10);
    for (int i = 0; i < 70; i++) begin
      if (i == 30) press(3, 10);
      step();
      checks++;
      if (led !== exp_led() || run_state !== 2'(ms) || pattern !== 1'(mpat)) begin
        failures++;
        $display("FAIL reset_mid_setup cyc=%0d led=%b/%b state=%0d/%0d pattern=%0d/%0d",
                 cyc, led, exp_led(), run_state, ms, pattern, mpat);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0001 || run_state !== 2'd0 || pattern !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid led=%b state=%0d pattern=%0d expected 0001/0/0", led, run_state, pattern);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (led !== exp_led() || run_state !== 2'(ms) || pattern !== 1'(mpat)) begin
        failures++;
        $display("FAIL reset_mid_after cyc=%0d led=%b/%b state=%0d/%0d pattern=%0d/%0d",
                 cyc, led, exp_led(), run_state, ms, pattern, mpat);
      end
    end
  endtask

  task automatic test_reset_debounce();
    press(1, 10);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (led !== exp_led() || run_state !== 2'(ms) || pattern !== 1'(mpat)) begin
        failures++;
        $display("FAIL reset_debounce cyc=%0d led=%b/%b state=%0d/%0d pattern=%0d/%0d",
                 cyc, led, exp_led(), run_state, ms, pattern, mpat);
      end
    end
    checks++;
    if (run_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_debounce_state state=%0d expected 0", run_state);
    end
  endtask

  task automatic test_random();
    int k, k2, hold, len;
    pulse_reset();
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 3);
      hold = $urandom_range(1, DEB + 6);
      if ($urandom_range(0, 3) == 0) speed = 2'($urandom_range(0, 3));
      press(k, hold);
      if ($urandom_range(0, 4) == 0) begin
        k2 = (k + $urandom_range(1, 3)) % 4;
        press(k2, $urandom_range(1, DEB + 6));
      end
      len = 2 * DEB + 12 + $urandom_range(0, 20);
      for (int i = 0; i < len; i++) begin
        step();
        checks++;
        if (led !== exp_led() || run_state !== 2'(ms) || pattern !== 1'(mpat)) begin
          failures++;
          $display("FAIL random it=%0d cyc=%0d led=%b/%b state=%0d/%0d pattern=%0d/%0d",
                   it, cyc, led, exp_led(), run_state, ms, pattern, mpat);
        end
      end
    end
    speed = 2'd0;
  endtask

  initial begin
    test_reset();
    test_left_glitch();
    test_johnson_left();
    test_bounce();
    test_priority_speed();
    test_reset_mid();
    test_reset_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter N_LED, default 4, LED count, legal range 2..32.
REQ-002 Parameter TICK_CYCLES, default 50_000_000, clk cycles per step at speed 0.
REQ-003 Parameter DEB_CYCLES, default 1_000_000, clk cycles a key must be stable to register.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_stop  input  1  async pushbutton, active-low: enter STOP.
REQ-007 key_left  input  1  async pushbutton, active-low: enter LEFT.
REQ-008 key_right  input  1  async pushbutton, active-low: enter RIGHT.
REQ-009 key_mode  input  1  async pushbutton, active-low: press in STOP enters BOUNCE; press in any moving state toggles pattern.
REQ-010 speed  input  2  step period = TICK_CYCLES >> speed.
REQ-011 led  output  N_LED  LED drive, active-high.
REQ-012 run_state  output  2  current state encoding: STOP=0, LEFT=1, RIGHT=2, BOUNCE=3.
REQ-013 pattern  output  1  0 = one-hot, 1 = Johnson.

Function
REQ-014 Each key SHALL pass a 2-flop synchroniser and debouncer, producing a one-cycle press pulse when the input has been low for DEB_CYCLES consecutive cycles; no further pulse until the input has been high for DEB_CYCLES.
REQ-015 Press-to-effect latency SHALL be 1 clk after the press pulse.
REQ-016 Simultaneous press pulses: priority stop > left > right > mode; lower-priority pulses in that cycle are discarded.
REQ-017 FSM transitions: stop pulse -> STOP from any state; left -> LEFT; right -> RIGHT; mode in STOP -> BOUNCE; an unencoded state -> STOP.
REQ-018 Tick counter: counts 0..(TICK_CYCLES>>speed)-1, emits a one-cycle tick at the terminal count, then wraps to 0; comparison is >= so a speed change never stalls it.
REQ-019 Tick counter clears to 0 on every state change and on every pattern toggle.
REQ-020 In STOP, led SHALL hold its value; ticks are ignored.
REQ-021 LEFT one-hot: led <= {led[N-2:0], led[N-1]}; LEFT Johnson: led <= {led[N-2:0], ~led[N-1]}.
REQ-022 RIGHT one-hot: led <= {led[0], led[N-1:1]}; RIGHT Johnson: led <= {~led[0], led[N-1:1]}.
REQ-023 BOUNCE keeps an internal dir bit (0 = toward MSB), applies the LEFT or RIGHT rule per dir, and flips dir on the step that produces: one-hot, led[N-1]=1 (up) or led[0]=1 (down); Johnson, all-ones (up) or all-zeros (down).
REQ-024 Entering BOUNCE SHALL set dir=0.
REQ-025 Pattern toggle SHALL reload led: one-hot -> bit0 = 1 only; Johnson -> all zeros; dir <= 0.
REQ-026 led updates only on tick, pattern reload, or reset; all outputs are registered.

Reset
REQ-027 While rst is high: led = 1 (bit0 only), run_state = STOP, pattern = 0, dir = 0, tick counter = 0, debouncers idle with no pulse pending.
REQ-028 Reset asserted mid-step or mid-debounce SHALL abort immediately; after release, no press pulse is produced until a fresh full DEB_CYCLES low period.

Structure
REQ-029 A shared package holds the run_state encodings, pattern encodings, and default parameter constants.
REQ-030 One sub-module, led_key_debounce (synchroniser + debounce + press pulse, parameter DEB_CYCLES), instantiated four times.
REQ-031 Top level contains the FSM, the tick counter and the shift datapath; target 120-400 lines total.

Verification (N_LED=4, TICK_CYCLES=8, DEB_CYCLES=4, speed=0)
REQ-032 Reset, no keys for 100 cycles -> led=0001, run_state=0 throughout.
REQ-033 key_left low 10 cycles -> LEFT; led steps 0010, 0100, 1000, 0001, one step every 8 cycles; a 2-cycle glitch on key_right -> no effect.
REQ-034 In LEFT, press key_mode -> pattern=1, led=0000, then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
REQ-035 In STOP, press key_mode (pattern 0) -> BOUNCE: 0010, 0100, 1000, 0100, 0010, 0001, 0010; in Johnson, 0001..1111 then 0111, 0011, 0001, 0000.
REQ-036 key_stop and key_right pressed in the same cycle during LEFT -> STOP, led frozen; with speed=3 afterwards in RIGHT -> one step per cycle.
REQ-037 rst pulsed mid-sequence in Johnson BOUNCE -> led=0001, pattern=0, run_state=0 on the next cycle.
